// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the core's fetch and data ports. A same-cycle conflict
// grants the priority port and replays the other one cycle later with its wait raised.
module mem_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_address,
  input  logic        imem_enable,
  output logic [31:0] imem_data,
  output logic        imem_wait,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  output logic [31:0] ram_address,
  output logic        ram_enable,
  output logic [31:0] ram_write_data,
  output logic        ram_write_enable,
  output logic [2:0]  ram_write_mode,
  output logic [2:0]  ram_read_mode,
  input  logic [31:0] ram_read_data,
  output logic [31:0] conflict_count
);

  localparam logic [2:0] FetchMode = 3'b010;

  typedef enum logic [1:0] {StIdle, StReplayI, StReplayD} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  wmode;
    logic [2:0]  rmode;
  } access_t;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  access_t     pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] imem_hold_q, dmem_hold_q;

  logic    i_req, d_req;
  access_t i_access, d_access, sel;

  assign i_req = imem_enable;
  assign d_req = dmem_enable & (dmem_read_enable | dmem_write_enable);

  always_comb begin
    i_access       = '0;
    i_access.addr  = imem_address;
    i_access.re    = 1'b1;
    i_access.rmode = FetchMode;

    d_access       = '0;
    d_access.addr  = dmem_address;
    d_access.wdata = dmem_write_data;
    d_access.we    = dmem_write_enable;
    d_access.re    = dmem_read_enable;
    d_access.wmode = dmem_write_mode;
    d_access.rmode = dmem_read_mode;
  end

  // sel is the access presented to the RAM this cycle; all-zero means no access.
  always_comb begin
    state_d = StIdle;
    owner_d = OwnNone;
    pend_d  = pend_q;
    count_d = count_q;
    sel     = '0;

    case (state_q)
      StReplayI: begin
        sel     = pend_q;
        owner_d = OwnI;
      end
      StReplayD: begin
        sel     = pend_q;
        owner_d = OwnD;
      end
      default: begin
        if (d_req && (DATA_PRIORITY || !i_req)) begin
          sel     = d_access;
          owner_d = OwnD;
        end else if (i_req) begin
          sel     = i_access;
          owner_d = OwnI;
        end
        if (i_req && d_req) begin
          count_d = count_q + 32'd1;
          pend_d  = DATA_PRIORITY ? i_access : d_access;
          state_d = DATA_PRIORITY ? StReplayI : StReplayD;
        end
      end
    endcase
  end

  // Strobes are suppressed in the reset cycle so a discarded replay never reaches the RAM.
  assign ram_address      = sel.addr;
  assign ram_write_data   = sel.wdata;
  assign ram_write_mode   = sel.wmode;
  assign ram_read_mode    = sel.rmode;
  assign ram_enable       = (sel.we | sel.re) & reset_n;
  assign ram_write_enable = sel.we & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      pend_q      <= '0;
      count_q     <= '0;
      imem_hold_q <= '0;
      dmem_hold_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      if (owner_q == OwnI) imem_hold_q <= ram_read_data;
      if (owner_q == OwnD) dmem_hold_q <= ram_read_data;
    end
  end

  assign imem_data      = (owner_q == OwnI) ? ram_read_data : imem_hold_q;
  assign dmem_read_data = (owner_q == OwnD) ? ram_read_data : dmem_hold_q;
  assign imem_wait      = (state_q == StReplayI);
  assign dmem_wait      = (state_q == StReplayD);
  assign conflict_count = count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: both priority settings share one stimulus stream; each instance has
// its own RAM, a sequential memory model feeding scoreboard queues, and a monitor.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_address = '0;
  logic        imem_enable = 1'b0;
  logic [31:0] dmem_address = '0;
  logic        dmem_enable = 1'b0;
  logic [31:0] dmem_write_data = '0;
  logic        dmem_write_enable = 1'b0;
  logic [2:0]  dmem_write_mode = '0;
  logic        dmem_read_enable = 1'b0;
  logic [2:0]  dmem_read_mode = '0;

  int cyc = 0;
  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  wmode;
    logic [2:0]  rmode;
  } req_t;

  typedef struct {
    int   due;
    req_t r;
  } rexp_t;

  typedef struct {
    int          due;
    logic [31:0] val;
  } dexp_t;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0000_0013;
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 + 32'(i) * 32'h0000_1001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit Prio = (g == 1);

    logic [31:0] imem_data, dmem_read_data, ram_address, ram_write_data, ram_read_data;
    logic [31:0] conflict_count;
    logic        imem_wait, dmem_wait, ram_enable, ram_write_enable;
    logic [2:0]  ram_write_mode, ram_read_mode;

    mem_arbiter #(.DATA_PRIORITY(Prio)) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .imem_address     (imem_address),
      .imem_enable      (imem_enable),
      .imem_data        (imem_data),
      .imem_wait        (imem_wait),
      .dmem_address     (dmem_address),
      .dmem_enable      (dmem_enable),
      .dmem_write_data  (dmem_write_data),
      .dmem_write_enable(dmem_write_enable),
      .dmem_write_mode  (dmem_write_mode),
      .dmem_read_enable (dmem_read_enable),
      .dmem_read_mode   (dmem_read_mode),
      .dmem_read_data   (dmem_read_data),
      .dmem_wait        (dmem_wait),
      .ram_address      (ram_address),
      .ram_enable       (ram_enable),
      .ram_write_data   (ram_write_data),
      .ram_write_enable (ram_write_enable),
      .ram_write_mode   (ram_write_mode),
      .ram_read_mode    (ram_read_mode),
      .ram_read_data    (ram_read_data),
      .conflict_count   (conflict_count)
    );

    // RAM device: 1-cycle latency, a write cycle returns the written word.
    logic [31:0] ram [256];
    bit   [255:0] ram_valid;
    always @(posedge clk) begin
      if (ram_enable) begin
        if (ram_write_enable) begin
          ram[ram_address[9:2]]       <= ram_write_data;
          ram_valid[ram_address[9:2]] <= 1'b1;
          ram_read_data               <= ram_write_data;
        end else begin
          ram_read_data <= ram_valid[ram_address[9:2]] ? ram[ram_address[9:2]]
                                                       : init_word(int'(ram_address[9:2]));
        end
      end
    end

    // Reference model state: memory contents as the core should see them, in service order.
    logic [31:0] mmem [256];
    bit   [255:0] mvalid;
    rexp_t       rq[$];
    dexp_t       iq[$];
    dexp_t       dq[$];
    logic [31:0] ilast = '0;
    logic [31:0] dlast = '0;
    logic [31:0] mcnt = '0;
    logic [31:0] exp_cnt = '0;
    bit          exp_iw, exp_dw, pend_v;
    req_t        pend;
    int          stores_model = 0;
    int          stores_seen = 0;

    task automatic serve(input req_t r);
      rexp_t       e;
      dexp_t       d;
      logic [7:0]  idx;
      logic [31:0] v;
      idx   = r.addr[9:2];
      e.due = cyc;
      e.r   = r;
      rq.push_back(e);
      if (r.we) begin
        mmem[idx]   = r.wdata;
        mvalid[idx] = 1'b1;
        v           = r.wdata;
        stores_model++;
      end else begin
        v = mvalid[idx] ? mmem[idx] : init_word(int'(idx));
      end
      d.due = cyc + 1;
      d.val = v;
      if (r.is_d) dq.push_back(d);
      else iq.push_back(d);
    endtask

    initial begin : model
      req_t fi, fd;
      logic ir, dr;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          rq.delete();
          iq.delete();
          dq.delete();
          ilast   = '0;
          dlast   = '0;
          mcnt    = '0;
          exp_cnt = '0;
          exp_iw  = 1'b0;
          exp_dw  = 1'b0;
          pend_v  = 1'b0;
        end else begin
          exp_iw  = pend_v && !pend.is_d;
          exp_dw  = pend_v && pend.is_d;
          exp_cnt = mcnt;
          if (pend_v) begin
            serve(pend);
            pend_v = 1'b0;
          end else begin
            ir       = imem_enable;
            dr       = dmem_enable && (dmem_read_enable || dmem_write_enable);
            fi.is_d  = 1'b0;
            fi.addr  = imem_address;
            fi.we    = 1'b0;
            fi.wdata = '0;
            fi.wmode = '0;
            fi.rmode = '0;
            fd.is_d  = 1'b1;
            fd.addr  = dmem_address;
            fd.we    = dmem_write_enable;
            fd.wdata = dmem_write_data;
            fd.wmode = dmem_write_mode;
            fd.rmode = dmem_read_mode;
            if (ir && dr) begin
              mcnt   = mcnt + 32'd1;
              pend_v = 1'b1;
              if (Prio) begin
                serve(fd);
                pend = fi;
              end else begin
                serve(fi);
                pend = fd;
              end
            end else if (ir) begin
              serve(fi);
            end else if (dr) begin
              serve(fd);
            end
          end
        end
      end
    end

    initial begin : monitor
      rexp_t e;
      forever begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
          chk($sformatf("p%0d ram_enable_in_reset", g), 32'(ram_enable), 32'd0);
          chk($sformatf("p%0d ram_write_in_reset", g), 32'(ram_write_enable), 32'd0);
        end else begin
          while (rq.size() != 0 && rq[0].due < cyc) begin
            fail_now($sformatf("p%0d ram_access_missing addr=%h", g, rq[0].r.addr));
            void'(rq.pop_front());
          end
          if (ram_enable) begin
            if (rq.size() == 0 || rq[0].due != cyc) begin
              fail_now($sformatf("p%0d ram_access_unexpected addr=%h", g, ram_address));
            end else begin
              e = rq.pop_front();
              chk($sformatf("p%0d ram_address", g), ram_address, e.r.addr);
              chk($sformatf("p%0d ram_write_enable", g), 32'(ram_write_enable), 32'(e.r.we));
              if (e.r.we) begin
                chk($sformatf("p%0d ram_write_data", g), ram_write_data, e.r.wdata);
                chk($sformatf("p%0d ram_write_mode", g), 32'(ram_write_mode), 32'(e.r.wmode));
              end else if (e.r.is_d) begin
                chk($sformatf("p%0d ram_read_mode", g), 32'(ram_read_mode), 32'(e.r.rmode));
              end
            end
            if (ram_write_enable) stores_seen++;
          end else begin
            chk($sformatf("p%0d ram_write_without_enable", g), 32'(ram_write_enable), 32'd0);
            if (rq.size() != 0 && rq[0].due == cyc) begin
              fail_now($sformatf("p%0d ram_access_missing addr=%h", g, rq[0].r.addr));
              void'(rq.pop_front());
            end
          end
          if (iq.size() != 0 && iq[0].due <= cyc) ilast = iq.pop_front().val;
          if (dq.size() != 0 && dq[0].due <= cyc) dlast = dq.pop_front().val;
          chk($sformatf("p%0d imem_data", g), imem_data, ilast);
          chk($sformatf("p%0d dmem_read_data", g), dmem_read_data, dlast);
          chk($sformatf("p%0d imem_wait", g), 32'(imem_wait), 32'(exp_iw));
          chk($sformatf("p%0d dmem_wait", g), 32'(dmem_wait), 32'(exp_dw));
          chk($sformatf("p%0d conflict_count", g), conflict_count, exp_cnt);
        end
      end
    end
  end

  task automatic idle_inputs();
    imem_enable       = 1'b0;
    imem_address      = '0;
    dmem_enable       = 1'b0;
    dmem_address      = '0;
    dmem_write_data   = '0;
    dmem_write_enable = 1'b0;
    dmem_write_mode   = '0;
    dmem_read_enable  = 1'b0;
    dmem_read_mode    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] a);
    imem_enable  = 1'b1;
    imem_address = a;
  endtask

  task automatic set_data(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    dmem_enable       = 1'b1;
    dmem_address      = a;
    dmem_write_enable = wr;
    dmem_read_enable  = !wr;
    dmem_write_data   = wd;
    dmem_write_mode   = 3'b010;
    dmem_read_mode    = 3'b010;
  endtask

  // Stalled cycles carry garbage: the arbiter must ignore core inputs while replaying.
  task automatic rand_cycle(input bit stall);
    if (stall) begin
      imem_enable       = ($urandom_range(0, 1) == 1);
      imem_address      = $urandom;
      dmem_enable       = ($urandom_range(0, 1) == 1);
      dmem_address      = $urandom;
      dmem_write_data   = $urandom;
      dmem_write_enable = ($urandom_range(0, 1) == 1);
      dmem_read_enable  = ($urandom_range(0, 1) == 1);
      dmem_write_mode   = 3'($urandom_range(0, 7));
      dmem_read_mode    = 3'($urandom_range(0, 7));
    end else begin
      int k;
      k                 = $urandom_range(0, 3);
      imem_enable       = ($urandom_range(0, 99) < 60);
      imem_address      = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      dmem_enable       = ($urandom_range(0, 99) < 75);
      dmem_address      = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      dmem_write_data   = $urandom;
      dmem_read_enable  = (k == 1);
      dmem_write_enable = (k == 2);
      dmem_write_mode   = 3'($urandom_range(0, 7));
      dmem_read_mode    = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    bit stall;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fetch only.
    set_fetch(32'h10);
    @(negedge clk);
    chk("fetch_only ram_address", g_inst[1].ram_address, 32'h10);
    chk("fetch_only ram_enable", 32'(g_inst[1].ram_enable), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("fetch_only imem_data", g_inst[1].imem_data, 32'h13);
    chk("fetch_only imem_wait", 32'(g_inst[1].imem_wait), 32'd0);
    step();

    // Fetch and load conflict.
    set_fetch(32'h20);
    set_data(32'h100, 1'b0, 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("p1 conflict replay ram_address", g_inst[1].ram_address, 32'h20);
    chk("p1 conflict imem_wait", 32'(g_inst[1].imem_wait), 32'd1);
    chk("p1 conflict load data", g_inst[1].dmem_read_data, 32'hDEAD_BEEF);
    chk("p0 conflict replay ram_address", g_inst[0].ram_address, 32'h100);
    chk("p0 conflict dmem_wait", 32'(g_inst[0].dmem_wait), 32'd1);
    step();
    @(negedge clk);
    chk("p1 conflict fetch data", g_inst[1].imem_data, init_word(8));
    chk("p1 conflict load held", g_inst[1].dmem_read_data, 32'hDEAD_BEEF);
    chk("p1 conflict_count", g_inst[1].conflict_count, 32'd1);
    chk("p0 conflict load data", g_inst[0].dmem_read_data, 32'hDEAD_BEEF);
    step();

    // Fetch and store conflict: deferred store under fetch priority.
    set_fetch(32'h20);
    set_data(32'h200, 1'b1, 32'h55);
    step();
    idle_inputs();
    @(negedge clk);
    chk("p0 deferred store strobe", 32'(g_inst[0].ram_write_enable), 32'd1);
    chk("p0 deferred store addr", g_inst[0].ram_address, 32'h200);
    chk("p0 deferred store data", g_inst[0].ram_write_data, 32'h55);
    chk("p0 deferred store dmem_wait", 32'(g_inst[0].dmem_wait), 32'd1);
    chk("p1 fetch replay no store", 32'(g_inst[1].ram_write_enable), 32'd0);
    step();

    // Same-word hazard.
    set_fetch(32'h40);
    set_data(32'h40, 1'b1, 32'hCAFE_F00D);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    chk("p1 hazard fetch sees store", g_inst[1].imem_data, 32'hCAFE_F00D);
    chk("p0 hazard fetch sees old", g_inst[0].imem_data, init_word(16));
    step();

    // Reset landing on the replay cycle.
    set_fetch(32'h30);
    set_data(32'h3C, 1'b1, 32'h77);
    step();
    idle_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("p1 post-reset imem_wait", 32'(g_inst[1].imem_wait), 32'd0);
    chk("p1 post-reset ram_enable", 32'(g_inst[1].ram_enable), 32'd0);
    chk("p1 post-reset conflict_count", g_inst[1].conflict_count, 32'd0);
    chk("p1 post-reset imem_data", g_inst[1].imem_data, 32'd0);
    chk("p1 post-reset dmem_read_data", g_inst[1].dmem_read_data, 32'd0);
    chk("p0 post-reset dmem_wait", 32'(g_inst[0].dmem_wait), 32'd0);
    chk("p0 post-reset ram_write_enable", 32'(g_inst[0].ram_write_enable), 32'd0);
    step();

    // Random traffic with a core that stalls for one cycle after every conflict.
    stall = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      rand_cycle(stall);
      stall = !stall && imem_enable && dmem_enable && (dmem_read_enable || dmem_write_enable);
      step();
    end
    idle_inputs();
    repeat (4) step();

    chk("p0 ram queue drained", 32'(g_inst[0].rq.size()), 32'd0);
    chk("p1 ram queue drained", 32'(g_inst[1].rq.size()), 32'd0);
    chk("p0 fetch queue drained", 32'(g_inst[0].iq.size()), 32'd0);
    chk("p1 data queue drained", 32'(g_inst[1].dq.size()), 32'd0);
    chk("p0 store count", 32'(g_inst[0].stores_seen), 32'(g_inst[0].stores_model));
    chk("p1 store count", 32'(g_inst[1].stores_seen), 32'(g_inst[1].stores_model));
    chk("p1 final conflict_count", g_inst[1].conflict_count, g_inst[1].mcnt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency unified RAM between the core's instruction-fetch port and data port, so the core can run on a single memory.
- Sits between the core's imem_*/dmem_* interfaces and the RAM.
- On a same-cycle conflict it grants one port, defers the other by one cycle, and raises that port's wait so the core pipeline stalls.
- Returned read data is held stable through stalls.

Parameters:
DATA_PRIORITY, 1, 1: the data port wins a conflict and fetch is deferred; 0: fetch wins and the data access is deferred.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
imem_address  in  32  fetch address
imem_enable  in  1  fetch request this cycle
imem_data  out  32  fetched word, valid the cycle after grant
imem_wait  out  1  fetch deferred; core must stall
dmem_address  in  32  data address
dmem_enable  in  1  data port enable
dmem_write_data  in  32  store data
dmem_write_enable  in  1  store request
dmem_write_mode  in  3  store size
dmem_read_enable  in  1  load request
dmem_read_mode  in  3  load size
dmem_read_data  out  32  load data, valid the cycle after grant
dmem_wait  out  1  data access deferred; core must stall
ram_address  out  32  shared RAM address
ram_enable  out  1  RAM access strobe
ram_write_data  out  32  RAM store data
ram_write_enable  out  1  RAM store strobe
ram_write_mode  out  3  RAM store size
ram_read_mode  out  3  RAM load size
ram_read_data  in  32  RAM output, valid 1 cycle after ram_enable
conflict_count  out  32  number of conflicts since reset

Behaviour:
- Request definitions:
  - i_req = imem_enable.
  - d_req = dmem_enable & (dmem_read_enable | dmem_write_enable).
- States: IDLE, REPLAY_I, REPLAY_D.
- owner register: NONE/I/D, records which port the previous cycle's RAM access served.
- IDLE with a single request:
  - Drive the RAM combinationally from that port.
  - ram_enable = 1; write strobe and modes pass through for the data port.
  - Set owner accordingly.
  - No wait is raised; latency is identical to a direct RAM connection.
- IDLE with no request: ram_enable = 0, ram_write_enable = 0, owner <= NONE.
- IDLE with both requests (conflict):
  - Grant the priority port.
  - Latch the loser's full request into a pending register: address; for data, also write data, write enable, read enable and both modes.
  - Go to REPLAY_I (loser is fetch) or REPLAY_D (loser is data).
  - conflict_count increments and wraps at 2^32.
- REPLAY_x (exactly 1 cycle):
  - Drive the RAM from the pending register, set owner = x, assert x_wait = 1.
  - All core-side inputs are ignored this cycle; the core is stalled and does not issue.
  - Next state is IDLE.
- Wait outputs are registered-state decodes only: imem_wait = (state == REPLAY_I), dmem_wait = (state == REPLAY_D). They are never asserted together.
- Read data path:
  - imem_data = ram_read_data when owner == I, else imem_hold. imem_hold <= ram_read_data whenever owner == I.
  - dmem_read_data follows the same rule with owner == D and dmem_hold.
  - Data therefore stays stable while the core is stalled.
- A deferred store is issued exactly once, in the REPLAY_D cycle. A granted store is never replayed.
- Reset:
  - state = IDLE, owner = NONE.
  - imem_hold = dmem_hold = 0, conflict_count = 0, pending register cleared.
  - All RAM strobes 0; imem_wait = dmem_wait = 0; imem_data = dmem_read_data = 0.
- Reset during REPLAY_x discards the pending access; no RAM strobe is issued in the reset cycle.
- Both ports addressing the same word in a conflict are served in priority order. With DATA_PRIORITY = 1, a fetch deferred behind a store to the same word returns the stored value.

Test Plan:
- Fetch only: imem_enable at 0x10 with RAM[0x10] = 0x00000013 -> ram_address = 0x10 in the same cycle; imem_data = 0x13 the next cycle; imem_wait never asserted.
- Conflict, DATA_PRIORITY = 1: fetch 0x20 and load 0x100 (RAM = 0xDEADBEEF) together.
  - Cycle N+1: RAM is issued 0x20, imem_wait = 1, dmem_read_data = 0xDEADBEEF.
  - Cycle N+2: imem_data = RAM[0x20], dmem_read_data still 0xDEADBEEF, conflict_count = 1.
- Conflict, DATA_PRIORITY = 0: fetch 0x20 and store 0x55 to 0x200 together.
  - Cycle N+1: ram_write_enable = 1 at 0x200 with data 0x55, dmem_wait = 1.
  - Exactly one store strobe is seen in total.
- Same-word hazard: store 0xCAFEF00D to 0x40 and fetch 0x40 together, DATA_PRIORITY = 1 -> imem_data = 0xCAFEF00D at N+2.
- Reset asserted during REPLAY_I -> next cycle imem_wait = 0, no RAM strobe, conflict_count = 0, outputs = 0.
- Back-to-back conflicts on 1000 cycles of random traffic with a core-stall model -> every request is served exactly once, in order per port, and conflict_count equals the number of conflicts counted by the model.
